// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Optional feature macro: HAZARD_PERF_CNT_EN (see hazard_stall_ctrl).
package hazard_pkg;

    // Top-level controller state: normal issue or frozen on a data-cache miss.
    typedef enum logic {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } state_t;

    // RV32I register file; RV32E builds override with 4.
    localparam int REG_ADDR_W_DEF = 5;

    // x0 is hard-wired to zero and never carries a real dependence.
    localparam int ZERO_REG = 0;

    // Width of the miss watchdog: it counts 0 .. timeout-1.
    function automatic int wd_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_load_scoreboard.sv
// Pending-load scoreboard: a shift register of {valid, rd} for loads that
// have left EX but whose data is not yet forwardable, plus source matching.
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    output logic                  match_out
);

    localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(ZERO_REG);

    generate
        if (DEPTH > 0) begin : g_sb
            logic [DEPTH-1:0]      valid;
            logic [REG_ADDR_W-1:0] rd [DEPTH];

            // Shift entries toward the oldest slot whenever EX/MEM advances.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    // NOTE: only the valid bits are reset; the rd payload is
                    // qualified by valid everywhere, so it needs no reset.
                    valid <= '0;
                end else if (shift_en) begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        valid[i] <= valid[i-1];
                        rd[i]    <= rd[i-1];
                    end
                    valid[0] <= push;
                    rd[0]    <= rd_in;
                end
            end

            // A used, non-x0 source hitting any valid pending load.
            always_comb begin
                // NOTE: default first so no path leaves match_out unassigned
                // (which would infer a latch).
                match_out = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid[i] && use_rs1 && rs1 != X0 && rs1 == rd[i])
                        match_out = 1'b1;
                    if (valid[i] && use_rs2 && rs2 != X0 && rs2 == rd[i])
                        match_out = 1'b1;
                end
            end
        end else begin : g_none
            // Single-cycle load latency: nothing is ever pending beyond EX.
            assign match_out = 1'b0;
            wire unused_sb = &{1'b0, clk, rst_n, shift_en, push, rd_in,
                               rs1, rs2, use_rs1, use_rs2};
        end
    endgenerate

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls
// with configurable load latency, data-cache miss freeze with a sticky
// watchdog, and taken-branch flush.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles / miss_cycles counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int LOAD_LAT     = 1,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  MemRead_ex,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  use_rs1_id,
    input  logic                  use_rs2_id,
    input  logic                  branch_taken_ex,
    input  logic                  dmem_stall,
    output logic                  load_delay,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  ID_EX_Write,
    output logic                  EX_MEM_Write,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  miss_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           miss_cycles
`endif
);

    localparam int                    WD_W   = wd_width(MISS_TIMEOUT);
    localparam logic [WD_W-1:0]       WD_MAX = WD_W'(MISS_TIMEOUT - 1);
    localparam logic [REG_ADDR_W-1:0] X0     = REG_ADDR_W'(ZERO_REG);

    state_t          state, state_next;
    logic [WD_W-1:0] wd;
    logic            ex_match, sb_match, hazard, push;

    // The load currently in EX is the youngest pending producer.
    assign ex_match = MemRead_ex &&
                      ((use_rs1_id && rs1_id != X0 && rs1_id == rd_ex) ||
                       (use_rs2_id && rs2_id != X0 && rs2_id == rd_ex));
    assign hazard   = ex_match || sb_match;

    // The load in EX is recorded even while it causes a bubble (the bubble
    // lands behind it); a squashed EX slot or a load to x0 is not.
    assign push = MemRead_ex && rd_ex != X0 && !flush_id_ex;

    load_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (LOAD_LAT - 1)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (EX_MEM_Write),
        .push      (push),
        .rd_in     (rd_ex),
        .rs1       (rs1_id),
        .rs2       (rs2_id),
        .use_rs1   (use_rs1_id),
        .use_rs2   (use_rs2_id),
        .match_out (sb_match)
    );

    // Next state and per-cycle control: freeze > branch flush > load-use.
    always_comb begin
        state_next   = state;
        load_delay   = 1'b0;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (rst_n) begin
            case (state)
                RUN:       state_next = dmem_stall ? MISS_WAIT : RUN;
                MISS_WAIT: state_next = dmem_stall ? MISS_WAIT : RUN;
                default:   state_next = RUN;
            endcase
            if (dmem_stall) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Write = 1'b0;
            end else if (branch_taken_ex) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (hazard) begin
                load_delay  = 1'b1;
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
            end
        end
    end

    // State register, saturating miss watchdog and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values.
            state        <= RUN;
            wd           <= '0;
            miss_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (state == MISS_WAIT && dmem_stall) begin
                if (wd != WD_MAX) wd <= wd + 1'b1;
                if (wd == WD_MAX) miss_timeout <= 1'b1;
            end else begin
                wd <= '0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            miss_cycles  <= '0;
        end else begin
            if (load_delay) stall_cycles <= stall_cycles + 32'd1;
            if ((state == RUN && dmem_stall) || state == MISS_WAIT)
                miss_cycles <= miss_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: two instances (LOAD_LAT=3 with
// MISS_TIMEOUT=8, and LOAD_LAT=1) share one directed stimulus stream.
// Optional macro HAZARD_PERF_CNT_EN enables the counter ports and checks.
module tb_hazard_stall_ctrl;

    // Output vector: {load_delay, PCWrite, IF_ID_Write, ID_EX_Write,
    //                 EX_MEM_Write, flush_if_id, flush_id_ex, miss_timeout}
    localparam logic [7:0] NRM = 8'b0111_1000;
    localparam logic [7:0] STL = 8'b1001_1000;
    localparam logic [7:0] FLS = 8'b0111_1110;
    localparam logic [7:0] FRZ = 8'b0000_0000;
    localparam logic [7:0] MT  = 8'b0000_0001;
    localparam logic [7:0] ALL = 8'hFF;
    localparam logic [7:0] NMT = 8'hFE;

    typedef struct {
        string      name;
        logic [7:0] exp3;
        logic [7:0] exp1;
        logic [7:0] mask;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic       MemRead_ex, use_rs1_id, use_rs2_id, branch_taken_ex, dmem_stall;

    logic ld3, pc3, ifid3, idex3, exmem3, fif3, fex3, mt3;
    logic ld1, pc1, ifid1, idex1, exmem1, fif1, fex1, mt1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc3, mc3, sc1, mc1;
`endif

    vec_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .MISS_TIMEOUT(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id),
        .use_rs2_id(use_rs2_id), .branch_taken_ex(branch_taken_ex),
        .dmem_stall(dmem_stall), .load_delay(ld3), .PCWrite(pc3),
        .IF_ID_Write(ifid3), .ID_EX_Write(idex3), .EX_MEM_Write(exmem3),
        .flush_if_id(fif3), .flush_id_ex(fex3), .miss_timeout(mt3)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc3), .miss_cycles(mc3)
`endif
    );

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .MISS_TIMEOUT(1024)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id),
        .use_rs2_id(use_rs2_id), .branch_taken_ex(branch_taken_ex),
        .dmem_stall(dmem_stall), .load_delay(ld1), .PCWrite(pc1),
        .IF_ID_Write(ifid1), .ID_EX_Write(idex1), .EX_MEM_Write(exmem1),
        .flush_if_id(fif1), .flush_id_ex(fex1), .miss_timeout(mt1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc1), .miss_cycles(mc1)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One cycle of stimulus, applied just after the rising edge.
    task automatic step(input string name, input logic rst,
                        input logic [4:0] rd, input logic mr,
                        input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic br, input logic ds,
                        input logic [7:0] e3, input logic [7:0] e1,
                        input logic [7:0] mask);
        vec_t v;
        @(posedge clk);
        #1;
        rst_n = rst; rd_ex = rd; MemRead_ex = mr;
        rs1_id = r1; use_rs1_id = u1; rs2_id = r2; use_rs2_id = u2;
        branch_taken_ex = br; dmem_stall = ds;
        v.name = name; v.exp3 = e3; v.exp1 = e1; v.mask = mask;
        q.push_back(v);
    endtask

    // Monitor: compares both instances on the falling edge of each cycle.
    initial begin
        vec_t v;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                v = q.pop_front();
                check({v.name, "/l3"},
                      32'({ld3, pc3, ifid3, idex3, exmem3, fif3, fex3, mt3} & v.mask),
                      32'(v.exp3 & v.mask));
                check({v.name, "/l1"},
                      32'({ld1, pc1, ifid1, idex1, exmem1, fif1, fex1, mt1} & v.mask),
                      32'(v.exp1 & v.mask));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rd_ex = '0; MemRead_ex = 1'b0; rs1_id = '0; rs2_id = '0;
        use_rs1_id = 1'b0; use_rs2_id = 1'b0; branch_taken_ex = 1'b0; dmem_stall = 1'b0;

        // Reset outputs, then an idle cycle.
        step("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM, NMT);
        step("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM, ALL);
        step("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM, ALL);

        // lw x5 ; add x6,x5,x1 back-to-back: 3 stalls at LAT=3, 1 at LAT=1.
        step("lu_a", 1, 5, 1, 5, 1, 1, 1, 0, 0, STL, STL, ALL);
        step("lu_b", 1, 0, 0, 5, 1, 1, 1, 0, 0, STL, NRM, ALL);
        step("lu_c", 1, 0, 0, 5, 1, 1, 1, 0, 0, STL, NRM, ALL);
        step("lu_d", 1, 0, 0, 5, 1, 1, 1, 0, 0, NRM, NRM, ALL);

        // One independent instruction between load and use: 2 stalls at LAT=3.
        step("gap_a", 1, 5, 1, 2, 1, 3, 1, 0, 0, NRM, NRM, ALL);
        step("gap_b", 1, 7, 0, 5, 1, 0, 0, 0, 0, STL, NRM, ALL);
        step("gap_c", 1, 0, 0, 5, 1, 0, 0, 0, 0, STL, NRM, ALL);
        step("gap_d", 1, 0, 0, 5, 1, 0, 0, 0, 0, NRM, NRM, ALL);

        // x0 never stalls; an unused source field never stalls.
        step("x0_a",    1, 0, 1, 0, 1, 0, 1, 0, 0, NRM, NRM, ALL);
        step("x0_b",    1, 0, 0, 0, 1, 0, 0, 0, 0, NRM, NRM, ALL);
        step("nouse_a", 1, 5, 1, 5, 0, 5, 0, 0, 0, NRM, NRM, ALL);
        step("nouse_b", 1, 0, 0, 5, 0, 0, 0, 0, 0, NRM, NRM, ALL);
        step("nouse_c", 1, 0, 0, 5, 0, 0, 0, 0, 0, NRM, NRM, ALL);

        // Taken branch beats a load-use hazard; the squashed load is not recorded.
        step("br_a", 1, 5, 1, 5, 1, 0, 0, 1, 0, FLS, FLS, ALL);
        step("br_b", 1, 0, 0, 5, 1, 0, 0, 0, 0, NRM, NRM, ALL);

        // Miss during a load-use stall: 10 frozen cycles, then the remaining
        // 2 stall cycles. The 10-cycle miss also trips the 8-cycle watchdog.
        step("frz_lu", 1, 5, 1, 5, 1, 0, 0, 0, 0, STL, STL, ALL);
        for (int i = 0; i < 10; i++)
            step("frz", 1, 0, 0, 5, 1, 0, 0, 0, 1, (i == 9) ? (FRZ | MT) : FRZ, FRZ, ALL);
        step("frz_rel0", 1, 0, 0, 5, 1, 0, 0, 0, 0, STL | MT, NRM, ALL);
        step("frz_rel1", 1, 0, 0, 5, 1, 0, 0, 0, 0, STL | MT, NRM, ALL);
        step("frz_rel2", 1, 0, 0, 5, 1, 0, 0, 0, 0, NRM | MT, NRM, ALL);

        step("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM, NMT);
        step("rst3", 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM, ALL);
        step("idle2", 1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM, ALL);

        // 20-cycle miss: timeout visible after 8 cycles in MISS_WAIT, sticky.
        for (int i = 0; i < 20; i++)
            step("to", 1, 0, 0, 0, 0, 0, 0, 0, 1, (i >= 9) ? (FRZ | MT) : FRZ, FRZ, ALL);
        step("to_rel",  1, 0, 0, 0, 0, 0, 0, 0, 0, NRM | MT, NRM, ALL);
        step("to_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, NRM | MT, NRM, ALL);
`ifdef HAZARD_PERF_CNT_EN
        check("miss_cycles/l3", mc3, 32'd21);
        check("miss_cycles/l1", mc1, 32'd21);
        check("stall_cycles/l3", sc3, 32'd0);
`endif

        // Reset in the middle of a miss: no residual freeze, timeout cleared.
        step("mm_a",     1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ | MT, FRZ, ALL);
        step("mm_b",     1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ | MT, FRZ, ALL);
        step("mm_rst",   0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, NRM, NMT);
        step("mm_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM, ALL);
        step("mm_lu",    1, 9, 1, 0, 0, 9, 1, 0, 0, STL, STL, ALL);

        // Drain the scoreboard queue with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
